// File: rtl/cvxif_copro_pkg.sv
// Shared types and constants for the CV-X-IF custom-0 coprocessor responder.
package cvxif_copro_pkg;

    localparam int XLEN      = 32;
    localparam int IdWidth   = 4;
    localparam int NrEntries = 2;

    localparam logic [6:0] OPC_CUSTOM0 = 7'b0001011;
    localparam logic [2:0] F3_CADD     = 3'b000;
    localparam logic [2:0] F3_CXOR     = 3'b001;
    localparam logic [2:0] F3_CMUL     = 3'b010;
    localparam logic [2:0] F3_CNOP     = 3'b011;

    typedef enum logic [1:0] {CADD, CXOR, CMUL, CNOP} op_e;

    typedef enum logic [1:0] {IDLE, EXEC, WAIT, RESP} fsm_e;

    typedef struct packed {
        logic               valid;
        logic [IdWidth-1:0] id;
        logic [4:0]         rd;
        op_e                op;
        logic [XLEN-1:0]    rs1;
        logic [XLEN-1:0]    rs2;
        logic               committed;
        logic               killed;
    } entry_t;

endpackage

// File: rtl/cvxif_copro_mul_iter.sv
// Iterative shift-add multiplier: one multiplier bit per cycle, first bit in the start cycle.
module cvxif_copro_mul_iter #(
    parameter int Width = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [Width-1:0] a_i,
    input  logic [Width-1:0] b_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [Width-1:0] product_o
);

    localparam int CntW = $clog2(Width);
    localparam logic [CntW-1:0] LastCnt = CntW'(Width - 1);

    logic [Width-1:0] acc_r;
    logic [Width-1:0] mcand_r;
    logic [Width-1:0] mplier_r;
    logic [CntW-1:0]  cnt_r;
    logic             busy_r;

    // Shift-add datapath and bit counter; done marks the cycle of the final bit.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            acc_r    <= '0;
            mcand_r  <= '0;
            mplier_r <= '0;
            cnt_r    <= '0;
            busy_r   <= 1'b0;
        end else if (start_i && !busy_r) begin
            acc_r    <= b_i[0] ? a_i : '0;
            mcand_r  <= a_i << 1;
            mplier_r <= b_i >> 1;
            cnt_r    <= CntW'(1);
            busy_r   <= 1'b1;
        end else if (busy_r) begin
            if (mplier_r[0]) begin
                acc_r <= acc_r + mcand_r;
            end
            mcand_r  <= mcand_r << 1;
            mplier_r <= mplier_r >> 1;
            if (cnt_r == LastCnt) begin
                cnt_r  <= '0;
                busy_r <= 1'b0;
            end else begin
                cnt_r <= cnt_r + CntW'(1);
            end
        end
    end

    assign busy_o    = busy_r;
    assign done_o    = busy_r && (cnt_r == LastCnt);
    assign product_o = acc_r;

endmodule

// File: rtl/cvxif_copro_responder.sv
// CV-X-IF responder: speculative issue into an in-order buffer, execute at head, respond after commit.
module cvxif_copro_responder
    import cvxif_copro_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               issue_valid_i,
    output logic               issue_ready_o,
    input  logic [31:0]        issue_instr_i,
    input  logic [IdWidth-1:0] issue_id_i,
    input  logic [XLEN-1:0]    issue_rs1_i,
    input  logic [XLEN-1:0]    issue_rs2_i,
    output logic               issue_accept_o,
    output logic               issue_writeback_o,
    input  logic               commit_valid_i,
    input  logic [IdWidth-1:0] commit_id_i,
    input  logic               commit_kill_i,
    output logic               result_valid_o,
    input  logic               result_ready_i,
    output logic [IdWidth-1:0] result_id_o,
    output logic [4:0]         result_rd_o,
    output logic [XLEN-1:0]    result_data_o,
    output logic               result_we_o
);

    localparam int PtrW = $clog2(NrEntries);
    localparam logic [PtrW:0] FullCnt = (PtrW + 1)'(NrEntries);

    entry_t          entries_r [NrEntries];
    logic [PtrW-1:0] head_r;
    logic [PtrW-1:0] tail_r;
    logic [PtrW:0]   count_r;
    fsm_e            state_r;

    entry_t          head_s;
    logic            dec_ok_s;
    op_e             dec_op_s;
    logic            alloc_s;
    logic            pop_s;
    logic [XLEN-1:0] alu_s;
    logic            mul_start_s;
    logic            mul_busy_s;
    logic            mul_done_s;
    logic [XLEN-1:0] mul_product_s;
    logic            unused_s;

    assign head_s   = entries_r[head_r];
    assign unused_s = ^issue_instr_i[24:15];

    // Instruction decode: custom-0 with funct7 zero, funct3 selects the op.
    always_comb begin
        dec_ok_s = 1'b0;
        dec_op_s = CNOP;
        if ((issue_instr_i[6:0] == OPC_CUSTOM0) && (issue_instr_i[31:25] == 7'b0000000)) begin
            case (issue_instr_i[14:12])
                F3_CADD: begin dec_ok_s = 1'b1; dec_op_s = CADD; end
                F3_CXOR: begin dec_ok_s = 1'b1; dec_op_s = CXOR; end
                F3_CMUL: begin dec_ok_s = 1'b1; dec_op_s = CMUL; end
                F3_CNOP: begin dec_ok_s = 1'b1; dec_op_s = CNOP; end
                default: begin dec_ok_s = 1'b0; dec_op_s = CNOP; end
            endcase
        end else begin
            dec_ok_s = 1'b0;
            dec_op_s = CNOP;
        end
    end

    assign issue_ready_o     = (count_r != FullCnt);
    assign issue_accept_o    = issue_valid_i & dec_ok_s;
    assign issue_writeback_o = issue_valid_i & dec_ok_s & (dec_op_s != CNOP);
    assign alloc_s           = issue_valid_i & issue_ready_o & dec_ok_s;

    // Single-cycle ALU on the head operands.
    always_comb begin
        alu_s = '0;
        case (head_s.op)
            CADD:    alu_s = head_s.rs1 + head_s.rs2;
            CXOR:    alu_s = head_s.rs1 ^ head_s.rs2;
            default: alu_s = '0;
        endcase
    end

    // Head retires when it is killed, a committed CNOP, or its result is taken.
    always_comb begin
        pop_s = 1'b0;
        case (state_r)
            WAIT: begin
                if (head_s.killed || (head_s.committed && (head_s.op == CNOP))) begin
                    pop_s = 1'b1;
                end else begin
                    pop_s = 1'b0;
                end
            end
            RESP: begin
                if (result_ready_i) begin
                    pop_s = 1'b1;
                end else begin
                    pop_s = 1'b0;
                end
            end
            default: pop_s = 1'b0;
        endcase
    end

    assign mul_start_s = (state_r == EXEC) && (head_s.op == CMUL) && !mul_busy_s;

    cvxif_copro_mul_iter #(
        .Width (XLEN)
    ) u_mul (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .start_i   (mul_start_s),
        .a_i       (head_s.rs1),
        .b_i       (head_s.rs2),
        .busy_o    (mul_busy_s),
        .done_o    (mul_done_s),
        .product_o (mul_product_s)
    );

    // Entry buffer: commit/kill marking, head retire, tail allocation, occupancy.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NrEntries; i++) begin
                entries_r[i] <= '0;
            end
            head_r  <= '0;
            tail_r  <= '0;
            count_r <= '0;
        end else begin
            for (int i = 0; i < NrEntries; i++) begin
                if (commit_valid_i && entries_r[i].valid && (entries_r[i].id == commit_id_i)) begin
                    if (commit_kill_i) begin
                        entries_r[i].killed <= 1'b1;
                    end else begin
                        entries_r[i].committed <= 1'b1;
                    end
                end
            end
            if (pop_s) begin
                entries_r[head_r].valid <= 1'b0;
                head_r                  <= head_r + PtrW'(1);
            end
            if (alloc_s) begin
                entries_r[tail_r] <= '{valid: 1'b1, id: issue_id_i, rd: issue_instr_i[11:7],
                                       op: dec_op_s, rs1: issue_rs1_i, rs2: issue_rs2_i,
                                       committed: 1'b0, killed: 1'b0};
                tail_r            <= tail_r + PtrW'(1);
            end
            case ({alloc_s, pop_s})
                2'b10:   count_r <= count_r + (PtrW + 1)'(1);
                2'b01:   count_r <= count_r - (PtrW + 1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Execution FSM with registered result port; an empty buffer lets a fresh issue start EXEC at once.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r        <= IDLE;
            result_valid_o <= 1'b0;
            result_id_o    <= '0;
            result_rd_o    <= '0;
            result_data_o  <= '0;
            result_we_o    <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (head_s.valid || alloc_s) begin
                        state_r <= EXEC;
                    end
                end
                EXEC: begin
                    if ((head_s.op != CMUL) || mul_done_s) begin
                        state_r <= WAIT;
                    end
                end
                WAIT: begin
                    if (head_s.killed) begin
                        state_r <= IDLE;
                    end else if (head_s.committed) begin
                        if (head_s.op == CNOP) begin
                            state_r <= IDLE;
                        end else begin
                            state_r        <= RESP;
                            result_valid_o <= 1'b1;
                            result_id_o    <= head_s.id;
                            result_rd_o    <= head_s.rd;
                            result_data_o  <= (head_s.op == CMUL) ? mul_product_s : alu_s;
                            result_we_o    <= 1'b1;
                        end
                    end
                end
                RESP: begin
                    if (result_ready_i) begin
                        state_r        <= IDLE;
                        result_valid_o <= 1'b0;
                        result_id_o    <= '0;
                        result_rd_o    <= '0;
                        result_data_o  <= '0;
                        result_we_o    <= 1'b0;
                    end
                end
                default: state_r <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/cvxif_copro_responder.md
# cvxif_copro_responder

Coprocessor-side (responder) endpoint of the CV-X-IF issue/commit/result protocol for the embedded 32-bit core configuration with CvxifEn set. Accepts custom-0 instructions speculatively from the core and holds them in an in-order entry buffer. It executes them on a single functional unit (1-cycle ALU ops, iterative multiply) and returns results to the core's writeback only after commit. Killed instructions are discarded without producing a result.

## Interface
- XLEN, 32, operand/result width
- IdWidth, 4, width of instruction ID from the core
- NrEntries, 2, in-order entry buffer depth (power of two, ≥2)

- clk_i  in  1  clock
- rst_i  in  1  reset, synchronous, active-high
- issue_valid_i  in  1  issue request valid
- issue_ready_o  out  1  issue request accepted this cycle
- issue_instr_i  in  32  instruction word
- issue_id_i  in  IdWidth  instruction ID
- issue_rs1_i, issue_rs2_i  in  XLEN  source operands (valid with issue_valid_i)
- issue_accept_o  out  1  instruction is ours (qualified by issue handshake)
- issue_writeback_o  out  1  instruction will write rd
- commit_valid_i  in  1  commit/kill event
- commit_id_i  in  IdWidth  ID being committed/killed
- commit_kill_i  in  1  1 = kill, 0 = commit
- result_valid_o  out  1  result available
- result_ready_i  in  1  core takes result
- result_id_o  out  IdWidth  ID of result
- result_rd_o  out  5  destination register
- result_data_o  out  XLEN  result value
- result_we_o  out  1  register write enable

## Operation
- Decode (combinational): opcode 7'b0001011 and funct7 = 0. funct3 000 CADD rs1+rs2 (mod 2^XLEN), 001 CXOR, 010 CMUL (low XLEN bits of unsigned product), 011 CNOP (no writeback). Other funct3 or opcode values: not accepted.
- Issue handshake is `issue_valid_i & issue_ready_o`. On the handshake, issue_accept_o/issue_writeback_o are valid in the same cycle. When accept=0, nothing is stored. issue_ready_o = ~full.
- Entry fields: id, rd, op, rs1, rs2, committed, killed. Entries are allocated at the tail in issue order.
- Commit: commit_valid_i marks the matching valid entry (ID compare) committed or killed. An unmatched ID is ignored. Commit and issue in the same cycle for the same ID cannot occur; the core guarantees this.
- Execution FSM on the head entry:
  - IDLE: if the head is valid, go to EXEC.
  - EXEC: CADD/CXOR/CNOP finish in 1 cycle. CMUL takes XLEN cycles, 1 bit per cycle, with a counter. Then go to WAIT.
  - WAIT: if killed, pop the head and go to IDLE. If committed and op=CNOP, pop and go to IDLE with no result. If committed otherwise, go to RESP.
  - RESP: result_valid_o=1. On result_ready_i, pop and go to IDLE.
- A kill during EXEC is recorded. Execution completes and the result is then discarded in WAIT; the iterative unit is never aborted mid-run.
- Result outputs are stable while result_valid_o & ~result_ready_i.
- result_we_o = 1 for CADD/CXOR/CMUL.

## Timing
- Reset: all entries invalid, FSM IDLE, counter 0. result_valid_o=0 and result outputs 0. issue_ready_o=1 in the first cycle after reset deasserts. Reset mid-CMUL or mid-RESP drops everything with no result emitted.
- Minimum issue-to-result latency, when committed in the issue cycle+1: CADD gives result_valid_o at cycle +3 (alloc, EXEC, WAIT→RESP). CMUL gives result_valid_o at cycle +XLEN+2.
- Full: with NrEntries valid, issue_ready_o=0. A pop and an issue in the same cycle do not free the slot for that issue; ready is based on registered occupancy.
- Pointers wrap modulo NrEntries. A count register distinguishes full from empty.
- Commit for the head entry in the same cycle as the EXEC→WAIT transition is taken into account in WAIT the next cycle.

## Structure
- Package cvxif_copro_pkg holds the opcode constant, funct3 constants, an op_e enum {CADD, CXOR, CMUL, CNOP}, the entry_t struct and the fsm_e state enum.
- Sub-module cvxif_copro_mul_iter: start/busy/done handshake, shift-add, XLEN-cycle counter.
- Everything else is in the top module.

## Test plan
- CADD rs1=0x0000_0005, rs2=0x0000_0007, id=3, committed next cycle → result_valid_o at +3 with data 0x0000_000C, id 3, we=1.
- CMUL rs1=0xFFFF_FFFF, rs2=0x0000_0002, committed → data 0xFFFF_FFFE after 32 busy cycles; result held under 5 cycles of result_ready_i=0.
- Issue opcode 7'b0110011 → issue_accept_o=0, no entry allocated, no result ever.
- Two CXOR issues (id 1, 2) with the buffer full → third issue sees issue_ready_o=0 until id 1's result handshake completes.
- CMUL id 4 killed at busy cycle 10 → no result_valid_o; following CADD id 5 produces its result normally.
- Assert rst_i during RESP → result_valid_o=0 the next cycle, issue_ready_o=1 after release, later commit for the old ID ignored.
